// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide widths plus the memory-arbiter state and owner types.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] SIZE_WORD = 3'b010;
    typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_LS} arb_owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and LSU requests.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise LSU has fixed priority.
module mem_arb_pick
    import riscv_pkg::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  arb_owner_t last,
    output arb_owner_t winner
);
`ifdef MEM_ARB_RR_EN
    always_comb winner = (if_req && ls_req) ? ((last == OWN_LS) ? OWN_IF : OWN_LS)
                                            : (ls_req ? OWN_LS : OWN_IF);
`else
    logic unused;
    assign unused = if_req ^ (last == OWN_LS);
    always_comb winner = ls_req ? OWN_LS : OWN_IF;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and LSU, one transaction outstanding.
// MEM_ARB_RR_EN enables round-robin arbitration (fixed LSU priority otherwise).
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int XLEN = riscv_pkg::XLEN
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_err_o,
    input  logic            ls_req_i,
    input  logic [XLEN-1:0] ls_adr_i,
    input  logic            ls_we_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [2:0]      ls_size_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            ls_err_o,
    input  logic            flush_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);
    import riscv_pkg::*;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t      state;
    arb_owner_t      owner, winner, last;
    logic [CW-1:0]   cnt;
    logic            discard, we;
    logic [XLEN-1:0] adr, wdata, rsp_data;
    logic [2:0]      size;
    logic            any_req, grant, timeout, done, flush_hit, rsp_err;

    mem_arb_pick u_pick (.if_req(if_req_i), .ls_req(ls_req_i), .last(last), .winner(winner));

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk)
        if (reset) last <= OWN_IF;
        else if (grant) last <= winner;
`else
    assign last = OWN_IF;
`endif

    assign any_req   = if_req_i || ls_req_i;
    assign grant     = !reset && state == IDLE && any_req;
    assign timeout   = state == RSP && !mem_rvalid_i && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign done      = !reset && state == RSP && (mem_rvalid_i || timeout);
    assign flush_hit = flush_i && owner == OWN_IF && state != IDLE;
    assign rsp_data  = timeout ? '0 : mem_rdata_i;
    assign rsp_err   = timeout || mem_err_i;

    assign if_gnt_o    = grant && winner == OWN_IF;
    assign ls_gnt_o    = grant && winner == OWN_LS;
    // a flush arriving with the response itself still kills the fetch return
    assign if_rvalid_o = done && owner == OWN_IF && !discard && !flush_hit;
    assign ls_rvalid_o = done && owner == OWN_LS;
    assign if_rdata_o  = if_rvalid_o ? rsp_data : '0;
    assign if_err_o    = if_rvalid_o && rsp_err;
    assign ls_rdata_o  = ls_rvalid_o ? rsp_data : '0;
    assign ls_err_o    = ls_rvalid_o && rsp_err;

    assign mem_req_o   = !reset && state == REQ;
    assign mem_adr_o   = adr;
    assign mem_we_o    = we;
    assign mem_wdata_o = wdata;
    assign mem_size_o  = size;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= OWN_IF;
            cnt     <= '0;
            discard <= 1'b0;
            adr     <= '0;
            we      <= 1'b0;
            wdata   <= '0;
            size    <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    state <= REQ;
                    owner <= winner;
                    adr   <= winner == OWN_LS ? ls_adr_i : if_adr_i;
                    we    <= winner == OWN_LS && ls_we_i;
                    wdata <= winner == OWN_LS ? ls_wdata_i : '0;
                    size  <= winner == OWN_LS ? ls_size_i : SIZE_WORD;
                end
                REQ: begin
                    discard <= discard || flush_hit;
                    if (mem_gnt_i) begin
                        state <= RSP;
                        cnt   <= '0;
                    end
                end
                default: begin
                    discard <= discard || flush_hit;
                    if (!mem_rvalid_i) cnt <= cnt + 1'b1;
                    if (mem_rvalid_i || timeout) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
